ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter_rr.sv | 23 ++
 rtl/ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;
  localparam int STAT_W  = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// slave: the arbiter's view; master: the surrounding SoC (requesters + RAM).
interface ram_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_enable;
  logic              ram_read_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_write_out;
  logic [DATA_W-1:0] ram_data_read_in;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_read_in,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
           ram_enable, ram_read_write, ram_address, ram_data_write_out
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_read_in,
    input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
           ram_enable, ram_read_write, ram_address, ram_data_write_out
  );
endinterface

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin grant logic, purely combinational.
// On a tie the requester that did not win last time is granted.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // One-hot grant; nothing granted while disabled.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM (1-cycle registered read) between
// the processor port (0) and the DMA/debug port (1), one transaction at a time.
// Optional build macro RAM_ARB_STATS_EN adds saturating grant/conflict counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_RAM_ADDRESS = 256,
  parameter int DATA_W          = 32
) (
  input  logic clk,
  input  logic reset,
  ram_arb_if.slave bus
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
  output logic [STAT_W-1:0] conflict_cnt
`endif
);

  localparam int ADDR_W = $clog2(NUM_RAM_ADDRESS);

  state_t            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              ram_en_q;
  logic              ram_rw_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              arb_en;
  logic [1:0]        grant;
  logic              owner_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Arbitration is only open in IDLE and never during reset.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arbiter_2 u_rr (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant)
  );

  // Winner's command, selected for latching in the ack cycle.
  always_comb begin
    owner_d = grant[REQ_DMA];
    we_d    = owner_d ? bus.we1    : bus.we0;
    addr_d  = owner_d ? bus.addr1  : bus.addr0;
    wdata_d = owner_d ? bus.wdata1 : bus.wdata0;
  end

  assign bus.ack0               = grant[REQ_CPU];
  assign bus.ack1               = grant[REQ_DMA];
  assign bus.rvalid0            = rvalid0_q;
  assign bus.rvalid1            = rvalid1_q;
  assign bus.rdata0             = rdata0_q;
  assign bus.rdata1             = rdata1_q;
  assign bus.ram_enable         = ram_en_q;
  assign bus.ram_read_write     = ram_rw_q;
  assign bus.ram_address        = ram_addr_q;
  assign bus.ram_data_write_out = ram_wdata_q;

  // Transaction FSM; the latched command doubles as the registered RAM strobe,
  // so ram_* are non-zero only during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant) begin
            owner_q      <= owner_d;
            last_grant_q <= owner_d;
            ram_en_q     <= 1'b1;
            ram_rw_q     <= we_d;
            ram_addr_q   <= addr_d;
            ram_wdata_q  <= wdata_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en_q    <= 1'b0;
          ram_rw_q    <= 1'b0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          state_q     <= ram_rw_q ? IDLE : RESP;
        end
        RESP: begin
          if (owner_q) begin
            rdata1_q  <= bus.ram_data_read_in;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= bus.ram_data_read_in;
            rvalid0_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [STAT_W-1:0] gcnt0_q, gcnt1_q, conf_q;

  // Saturating per-requester grant counters and a tie counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      conf_q  <= '0;
    end else begin
      if (grant[REQ_CPU]) gcnt0_q <= sat_inc(gcnt0_q);
      if (grant[REQ_DMA]) gcnt1_q <= sat_inc(gcnt1_q);
      if (arb_en && bus.req0 && bus.req1) conf_q <= sat_inc(conf_q);
    end
  end

  assign grant_cnt0   = gcnt0_q;
  assign grant_cnt1   = gcnt1_q;
  assign conflict_cnt = conf_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a cycle-scheduled transaction model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_ram_arbiter;

  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_arb_if #(.ADDR_W(8), .DATA_W(32)) bus ();

`ifdef RAM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  ram_arbiter #(.NUM_RAM_ADDRESS(256), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RAM_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  function automatic logic [31:0] pat(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {8'hA5, a, ~a, 8'h5A};
  endfunction

  // RAM instance stand-in: synchronous write, registered read.
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else if (bus.ram_enable) begin
      if (bus.ram_read_write) mem[bus.ram_address] <= bus.ram_data_write_out;
      else rd_q <= mem[bus.ram_address];
    end
  end
  assign bus.ram_data_read_in = rd_q;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    else n_pass++;
  endtask

  // Model: scheduled outputs per cycle index.
  int          cyc = 0;
  int          free_at = 0;
  bit          last_g = 1'b1;
  bit          zero_pend = 1'b0;
  logic [31:0] mdl_mem [256];
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
  bit          sc_en  [MAXC];
  bit          sc_rw  [MAXC];
  bit [7:0]    sc_ad  [MAXC];
  bit [31:0]   sc_wd  [MAXC];
  bit          sc_rv0 [MAXC];
  bit          sc_rv1 [MAXC];
  bit [31:0]   sc_rd  [MAXC];
`ifdef RAM_ARB_STATS_EN
  logic [15:0] mg0 = '0, mg1 = '0, mcf = '0;
`endif

  // Observations for the directed literal checks.
  bit   s_ack0, s_ack1;
  bit   grants[$];
  int   last_ack_cyc, rv0_cyc = -1, rv1_cyc = -1;
  logic [31:0] rv0_dat, rv1_dat;
  int   both_rv = 0, rv_cnt = 0, en_cnt = 0, wr_cnt = 0, ack1_cnt = 0;
  logic [63:0] s_or;

  task automatic check_cycle();
    int c;
    bit idle, w, e_ack0, e_ack1, we;
    logic [7:0] a;
    logic [31:0] d;
    c = cyc;
    if (c >= MAXC - 4) begin
      $display("FAIL cycle_budget cyc=%0d got=over want=under", c);
      $fatal(1);
    end
    if (zero_pend) begin exp_rd0 = '0; exp_rd1 = '0; zero_pend = 1'b0; end
    if (sc_rv0[c]) exp_rd0 = sc_rd[c];
    if (sc_rv1[c]) exp_rd1 = sc_rd[c];
    idle = !reset && (c >= free_at);
    e_ack0 = 1'b0; e_ack1 = 1'b0;
    if (idle && (bus.req0 || bus.req1)) begin
      w  = (bus.req0 && bus.req1) ? ~last_g : bus.req1;
      we = w ? bus.we1 : bus.we0;
      a  = w ? bus.addr1 : bus.addr0;
      d  = w ? bus.wdata1 : bus.wdata0;
      if (w) e_ack1 = 1'b1; else e_ack0 = 1'b1;
      last_g = w;
      sc_en[c+1] = 1'b1; sc_rw[c+1] = we; sc_ad[c+1] = a; sc_wd[c+1] = d;
      if (we) begin
        mdl_mem[a] = d;
        free_at = c + 2;
      end else begin
        if (w) sc_rv1[c+3] = 1'b1; else sc_rv0[c+3] = 1'b1;
        sc_rd[c+3] = mdl_mem[a];
        free_at = c + 3;
      end
    end
    chk("ack0", bus.ack0, e_ack0);
    chk("ack1", bus.ack1, e_ack1);
    chk("rvalid0", bus.rvalid0, sc_rv0[c]);
    chk("rvalid1", bus.rvalid1, sc_rv1[c]);
    chk("rdata0", bus.rdata0, exp_rd0);
    chk("rdata1", bus.rdata1, exp_rd1);
    chk("ram_enable", bus.ram_enable, sc_en[c]);
    chk("ram_read_write", bus.ram_read_write, sc_en[c] ? sc_rw[c] : 1'b0);
    chk("ram_address", bus.ram_address, sc_en[c] ? sc_ad[c] : 8'h00);
    chk("ram_data_write_out", bus.ram_data_write_out, sc_en[c] ? sc_wd[c] : 32'h0);
`ifdef RAM_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, mg0);
    chk("grant_cnt1", grant_cnt1, mg1);
    chk("conflict_cnt", conflict_cnt, mcf);
    if (reset) begin
      mg0 = '0; mg1 = '0; mcf = '0;
    end else begin
      if (e_ack0 && mg0 != 16'hFFFF) mg0++;
      if (e_ack1 && mg1 != 16'hFFFF) mg1++;
      if (idle && bus.req0 && bus.req1 && mcf != 16'hFFFF) mcf++;
    end
`endif
    if (reset) begin
      for (int i = c + 1; i < MAXC; i++) begin
        sc_en[i] = 0; sc_rw[i] = 0; sc_ad[i] = 0; sc_wd[i] = 0;
        sc_rv0[i] = 0; sc_rv1[i] = 0; sc_rd[i] = 0;
      end
      free_at = c + 1;
      last_g = 1'b1;
      zero_pend = 1'b1;
    end
    s_ack0 = bus.ack0;
    s_ack1 = bus.ack1;
    if (bus.ack0) begin grants.push_back(1'b0); last_ack_cyc = c; end
    if (bus.ack1) begin grants.push_back(1'b1); last_ack_cyc = c; ack1_cnt++; end
    if (bus.rvalid0) begin rv0_cyc = c; rv0_dat = bus.rdata0; rv_cnt++; end
    if (bus.rvalid1) begin rv1_cyc = c; rv1_dat = bus.rdata1; rv_cnt++; end
    if (bus.rvalid0 && bus.rvalid1) both_rv++;
    if (bus.ram_enable) begin en_cnt++; if (bus.ram_read_write) wr_cnt++; end
    s_or = {63'(0), |{bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
                     bus.ram_enable, bus.ram_read_write, bus.ram_address, bus.ram_data_write_out}};
  endtask

  task automatic tick();
    #1;
    check_cycle();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_req(input bit n, input bit we, input logic [7:0] a,
                        input logic [31:0] d, output int waited);
    waited = -1;
    if (n) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (n ? s_ack1 : s_ack0) begin waited = k; break; end
    end
    if (n) bus.req1 = 0; else bus.req0 = 0;
    if (waited < 0) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int w, rd_ack, idx, snap_en, snap_rv, snap_a1, got;
    for (int i = 0; i < 256; i++) mdl_mem[i] = pat(i);
    reset = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    @(negedge clk);
    tick();
    chk("reset_outputs_zero", s_or, 64'd0);
    tick();
    reset = 1'b0;

    // Write then read back, single requester.
    snap_en = en_cnt;
    do_req(0, 1, 8'h10, 32'hDEADBEEF, w);
    chk("wr_ack_first_cycle", w, 0);
    do_req(0, 0, 8'h10, 32'h0, w);
    rd_ack = last_ack_cyc;
    chk("rd_ack_two_after_write", w, 1);
    idle_ticks(4);
    chk("rd_latency", rv0_cyc - rd_ack, 3);
    chk("rd_data_literal", rv0_dat, 32'hDEADBEEF);
    chk("t1_ram_accesses", en_cnt - snap_en, 2);

    // Simultaneous held reads after reset.
    reset = 1'b1; tick(); reset = 1'b0;
    grants.delete();
    both_rv = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h20;
    idle_ticks(14);
    bus.req0 = 0; bus.req1 = 0;
    idle_ticks(4);
    if (grants.size() >= 4)
      chk("rr_alternate", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
    else
      chk("rr_grant_count", grants.size(), 4);
    chk("no_dual_rvalid", both_rv, 0);
    chk("rd0_literal", rv0_dat, 32'hDEADBEEF);
    chk("rd1_literal", rv1_dat, 32'hA520DF5A);

    // Held req1 while req0 pulses (req0 issues writes).
    grants.delete();
    for (int k = 0; k < 12; k++) begin
      bus.req0 = (k % 2 == 0); bus.we0 = 1; bus.addr0 = 8'h31; bus.wdata0 = 32'h12345678;
      if (k == 1) begin bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h30; end
      tick();
      if (s_ack1) bus.req1 = 0;
    end
    bus.req0 = 0; bus.req1 = 0;
    idle_ticks(4);
    idx = -1;
    foreach (grants[i]) if (grants[i] && idx < 0) idx = i;
    chk("held_req1_within_2_grants", (idx >= 0 && idx < 2), 1);

    // Reset during a read's RESP cycle.
    do_req(0, 0, 8'h40, 32'h0, w);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    snap_rv = rv_cnt;
    tick();
    chk("post_reset_outputs_zero", s_or, 64'd0);
    idle_ticks(3);
    chk("no_rvalid_after_reset", rv_cnt - snap_rv, 0);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h11;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h22;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      tick();
      if (s_ack0 || s_ack1) got = s_ack1 ? 2 : 1;
    end
    bus.req0 = 0; bus.req1 = 0;
    chk("first_tie_after_reset_to_req0", got, 1);
    idle_ticks(4);

    // req1 raised in ISSUE and withdrawn before IDLE.
    do_req(0, 0, 8'h50, 32'h0, w);
    snap_en = en_cnt; snap_a1 = ack1_cnt;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h60; bus.wdata1 = 32'hCAFEF00D;
    tick();
    bus.req1 = 0;
    idle_ticks(5);
    chk("withdrawn_no_ack1", ack1_cnt - snap_a1, 0);
    chk("withdrawn_ram_accesses", en_cnt - snap_en, 1);

`ifdef RAM_ARB_STATS_EN
    // Saturation of grant_cnt0.
    force dut.gcnt0_q = 16'hFFFE;
    mg0 = 16'hFFFE;
    tick();
    release dut.gcnt0_q;
    for (int k = 0; k < 3; k++) do_req(0, 1, 8'h70, 32'h0 + k, w);
    idle_ticks(3);
    chk("grant_cnt0_saturated", grant_cnt0, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
